// File: rtl/adc_spi_responder.sv
// adc_spi_responder
// MCP3202-style SPI responder on the fabric clock. It synchronizes the SPI pads,
// detects SCLK/CS edges, and serves a 12-bit sample taken from fabric inputs.
// The sample is either channel 0, channel 1, or a clamped difference of the two.
// It is used both on boards without an ADC fitted and as a loopback model for benches.

module adc_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        adc_clk,
    input  logic        adc_cs,
    input  logic        adc_mosi,
    output logic        adc_miso,
    output logic        adc_miso_oe,
    input  logic [11:0] sample_ch0,
    input  logic [11:0] sample_ch1,
    output logic        xfer_done,
    output logic        xfer_abort,
    output logic [2:0]  xfer_cfg
);

    typedef enum logic [2:0] {
        ARM   = 3'd0,
        IDLE  = 3'd1,
        START = 3'd2,
        CFG   = 3'd3,
        NULLB = 3'd4,
        MSB   = 3'd5,
        LSB   = 3'd6,
        TAIL  = 3'd7
    } state_t;

    // Unsigned a - b computed on 13 bits; a negative result clamps to zero.
    function automatic logic [11:0] sat_sub(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] diff;
        logic [11:0] res;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[12]) begin
            res = 12'd0;
        end else begin
            res = diff[11:0];
        end
        return res;
    endfunction

    // Source selection from the {SGL, ODD} configuration bits.
    function automatic logic [11:0] select_source(input logic sgl, input logic odd,
                                                  input logic [11:0] ch0, input logic [11:0] ch1);
        logic [11:0] res;
        case ({sgl, odd})
            2'b10:   res = ch0;
            2'b11:   res = ch1;
            2'b00:   res = sat_sub(ch0, ch1);
            2'b01:   res = sat_sub(ch1, ch0);
            default: res = 12'd0;
        endcase
        return res;
    endfunction

    // Synchronizers and the edge-detect delay stage
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   cs_d_r;
    logic                   sclk_d_r;

    logic cs_s;
    logic sclk_s;
    logic mosi_s;
    logic cs_fall_s;
    logic cs_rise_s;
    logic sclk_rise_s;
    logic sclk_fall_s;

    // Registered events, aligned with the MOSI value seen at the SCLK edge
    logic ev_cs_fall_r;
    logic ev_cs_rise_r;
    logic ev_sclk_rise_r;
    logic ev_sclk_fall_r;
    logic ev_mosi_r;

    // FSM state and datapath registers
    state_t      state_r;
    logic [2:0]  arm_cnt_r;
    logic [3:0]  bit_cnt_r;
    logic [1:0]  cfg_cnt_r;
    logic [1:0]  cfg_sh_r;
    logic [2:0]  cur_cfg_r;
    logic [11:0] hold_r;

    // Next-state values
    state_t      state_nxt_s;
    logic [2:0]  arm_cnt_nxt_s;
    logic [3:0]  bit_cnt_nxt_s;
    logic [1:0]  cfg_cnt_nxt_s;
    logic [1:0]  cfg_sh_nxt_s;
    logic [2:0]  cur_cfg_nxt_s;
    logic [11:0] hold_nxt_s;
    logic        miso_nxt_s;
    logic        oe_nxt_s;
    logic        done_nxt_s;
    logic        abort_nxt_s;
    logic [2:0]  xfer_cfg_nxt_s;

    assign cs_s   = cs_sync_r[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

    // SCLK edges only count while the synchronized chip select is low.
    assign cs_fall_s   = ~cs_s & cs_d_r;
    assign cs_rise_s   = cs_s & ~cs_d_r;
    assign sclk_rise_s = sclk_s & ~sclk_d_r & ~cs_s;
    assign sclk_fall_s = ~sclk_s & sclk_d_r & ~cs_s;

    // Pad synchronizers plus one delay stage; reset to the bus idle levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            cs_d_r      <= 1'b1;
            sclk_d_r    <= 1'b0;
        end else begin
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], adc_cs};
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], adc_clk};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], adc_mosi};
            cs_d_r      <= cs_s;
            sclk_d_r    <= sclk_s;
        end
    end

    // Register the detected edges so the FSM sees clean single-cycle events.
    always_ff @(posedge clk) begin
        if (reset) begin
            ev_cs_fall_r   <= 1'b0;
            ev_cs_rise_r   <= 1'b0;
            ev_sclk_rise_r <= 1'b0;
            ev_sclk_fall_r <= 1'b0;
            ev_mosi_r      <= 1'b0;
        end else begin
            ev_cs_fall_r   <= cs_fall_s;
            ev_cs_rise_r   <= cs_rise_s;
            ev_sclk_rise_r <= sclk_rise_s;
            ev_sclk_fall_r <= sclk_fall_s;
            ev_mosi_r      <= mosi_s;
        end
    end

    // FSM next-state and output decisions; cs rise takes priority over any SCLK edge.
    always_comb begin
        state_nxt_s    = state_r;
        arm_cnt_nxt_s  = arm_cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        cfg_cnt_nxt_s  = cfg_cnt_r;
        cfg_sh_nxt_s   = cfg_sh_r;
        cur_cfg_nxt_s  = cur_cfg_r;
        hold_nxt_s     = hold_r;
        miso_nxt_s     = adc_miso;
        oe_nxt_s       = adc_miso_oe;
        done_nxt_s     = 1'b0;
        abort_nxt_s    = 1'b0;
        xfer_cfg_nxt_s = xfer_cfg;

        case (state_r)
            ARM: begin
                // Let the synchronizer pipeline refill with real pad values before
                // trusting cs, so a select already low at reset release is skipped.
                if (arm_cnt_r == 3'd7) begin
                    if (cs_d_r) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = ARM;
                    end
                end else begin
                    arm_cnt_nxt_s = arm_cnt_r + 3'd1;
                end
            end

            IDLE: begin
                if (ev_cs_fall_r) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            START: begin
                if (ev_cs_rise_r) begin
                    state_nxt_s = IDLE;
                end else if (ev_sclk_rise_r) begin
                    if (ev_mosi_r) begin
                        state_nxt_s   = CFG;
                        cfg_cnt_nxt_s = 2'd0;
                        cfg_sh_nxt_s  = 2'b00;
                    end else begin
                        state_nxt_s = START;
                    end
                end else begin
                    state_nxt_s = START;
                end
            end

            CFG: begin
                if (ev_cs_rise_r) begin
                    state_nxt_s = IDLE;
                    abort_nxt_s = 1'b1;
                    oe_nxt_s    = 1'b0;
                    miso_nxt_s  = 1'b0;
                end else if (ev_sclk_rise_r) begin
                    if (cfg_cnt_r == 2'd2) begin
                        // MSBF arrives: freeze the configuration and the sample.
                        cur_cfg_nxt_s = {cfg_sh_r, ev_mosi_r};
                        hold_nxt_s    = select_source(cfg_sh_r[1], cfg_sh_r[0],
                                                      sample_ch0, sample_ch1);
                        state_nxt_s   = NULLB;
                    end else begin
                        cfg_sh_nxt_s  = {cfg_sh_r[0], ev_mosi_r};
                        cfg_cnt_nxt_s = cfg_cnt_r + 2'd1;
                    end
                end else begin
                    state_nxt_s = CFG;
                end
            end

            NULLB: begin
                if (ev_cs_rise_r) begin
                    state_nxt_s = IDLE;
                    abort_nxt_s = 1'b1;
                    oe_nxt_s    = 1'b0;
                    miso_nxt_s  = 1'b0;
                end else if (ev_sclk_fall_r) begin
                    oe_nxt_s      = 1'b1;
                    miso_nxt_s    = 1'b0;
                    bit_cnt_nxt_s = 4'd11;
                    state_nxt_s   = MSB;
                end else begin
                    state_nxt_s = NULLB;
                end
            end

            MSB: begin
                if (ev_cs_rise_r) begin
                    state_nxt_s = IDLE;
                    abort_nxt_s = 1'b1;
                    oe_nxt_s    = 1'b0;
                    miso_nxt_s  = 1'b0;
                end else if (ev_sclk_fall_r) begin
                    miso_nxt_s = hold_r[bit_cnt_r];
                    if (bit_cnt_r == 4'd0) begin
                        if (cur_cfg_r[0]) begin
                            state_nxt_s = TAIL;
                        end else begin
                            // B0 is shared; the LSB-first phase starts at B1.
                            state_nxt_s   = LSB;
                            bit_cnt_nxt_s = 4'd1;
                        end
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r - 4'd1;
                    end
                end else begin
                    state_nxt_s = MSB;
                end
            end

            LSB: begin
                if (ev_cs_rise_r) begin
                    state_nxt_s = IDLE;
                    abort_nxt_s = 1'b1;
                    oe_nxt_s    = 1'b0;
                    miso_nxt_s  = 1'b0;
                end else if (ev_sclk_fall_r) begin
                    miso_nxt_s = hold_r[bit_cnt_r];
                    if (bit_cnt_r == 4'd11) begin
                        state_nxt_s = TAIL;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                    end
                end else begin
                    state_nxt_s = LSB;
                end
            end

            TAIL: begin
                if (ev_cs_rise_r) begin
                    state_nxt_s    = IDLE;
                    done_nxt_s     = 1'b1;
                    xfer_cfg_nxt_s = cur_cfg_r;
                    oe_nxt_s       = 1'b0;
                    miso_nxt_s     = 1'b0;
                end else if (ev_sclk_fall_r) begin
                    miso_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = TAIL;
                end
            end

            default: begin
                state_nxt_s = ARM;
                oe_nxt_s    = 1'b0;
                miso_nxt_s  = 1'b0;
            end
        endcase
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ARM;
            arm_cnt_r   <= 3'd0;
            bit_cnt_r   <= 4'd0;
            cfg_cnt_r   <= 2'd0;
            cfg_sh_r    <= 2'b00;
            cur_cfg_r   <= 3'b000;
            hold_r      <= 12'd0;
            adc_miso    <= 1'b0;
            adc_miso_oe <= 1'b0;
            xfer_done   <= 1'b0;
            xfer_abort  <= 1'b0;
            xfer_cfg    <= 3'b000;
        end else begin
            state_r     <= state_nxt_s;
            arm_cnt_r   <= arm_cnt_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            cfg_cnt_r   <= cfg_cnt_nxt_s;
            cfg_sh_r    <= cfg_sh_nxt_s;
            cur_cfg_r   <= cur_cfg_nxt_s;
            hold_r      <= hold_nxt_s;
            adc_miso    <= miso_nxt_s;
            adc_miso_oe <= oe_nxt_s;
            xfer_done   <= done_nxt_s;
            xfer_abort  <= abort_nxt_s;
            xfer_cfg    <= xfer_cfg_nxt_s;
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: acts as the SPI master, builds the expected MISO
// stream from the converter's rules, and checks data, enables and status pulses.

module tb_adc_spi_responder;

    localparam int H = 8;   // SCLK half period in clk cycles

    logic        clk = 1'b0;
    logic        reset;
    logic        adc_clk;
    logic        adc_cs;
    logic        adc_mosi;
    logic        adc_miso;
    logic        adc_miso_oe;
    logic [11:0] sample_ch0;
    logic [11:0] sample_ch1;
    logic        xfer_done;
    logic        xfer_abort;
    logic [2:0]  xfer_cfg;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   done_cnt  = 0;
    int   abort_cnt = 0;
    bit   oe_seen   = 1'b0;
    logic [2:0] last_cfg = 3'b000;

    adc_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .adc_clk     (adc_clk),
        .adc_cs      (adc_cs),
        .adc_mosi    (adc_mosi),
        .adc_miso    (adc_miso),
        .adc_miso_oe (adc_miso_oe),
        .sample_ch0  (sample_ch0),
        .sample_ch1  (sample_ch1),
        .xfer_done   (xfer_done),
        .xfer_abort  (xfer_abort),
        .xfer_cfg    (xfer_cfg)
    );

    always #5 clk = ~clk;

    // Count status pulse cycles and note any drive enable, sampled after each edge.
    always @(posedge clk) begin
        #2;
        if (xfer_done)   done_cnt++;
        if (xfer_abort)  abort_cnt++;
        if (adc_miso_oe) oe_seen = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Converter result from the datasheet rules, using plain integer arithmetic.
    function automatic int model_val(input bit sgl, input bit odd, input int c0, input int c1);
        if (sgl) return odd ? c1 : c0;
        if (odd) return (c1 > c0) ? (c1 - c0) : 0;
        return (c0 > c1) ? (c0 - c1) : 0;
    endfunction

    // Drop cs, clock out leading zeros, start bit and SGL/ODD/MSBF; SCLK is left high.
    task automatic header(input int lead, input logic [2:0] cfg, input bit chg);
        int n;
        bit b;
        n = lead + 4;
        adc_cs = 1'b0;
        tick(H);
        for (int i = 0; i < n; i++) begin
            if (i < lead)       b = 1'b0;
            else if (i == lead) b = 1'b1;
            else                b = cfg[3 - (i - lead)];
            adc_mosi = b;
            tick(H);
            adc_clk = 1'b1;
            if (i == n - 1 && chg) begin
                tick(5);
                sample_ch0 = sample_ch0 ^ 12'hFFF;
                tick(H - 5);
            end else begin
                tick(H);
            end
            if (i != n - 1) adc_clk = 1'b0;
        end
        adc_mosi = 1'b0;
    endtask

    task automatic run_xfer(input string tag, input int lead, input logic [2:0] cfg,
                            input int nfalls, input bit chg);
        int v;
        int q[$];
        int frame;
        bit complete;
        v = model_val(cfg[2], cfg[1], int'(sample_ch0), int'(sample_ch1));
        q.push_back(0);
        for (int b = 11; b >= 0; b--) q.push_back((v >> b) & 1);
        if (!cfg[0]) for (int b = 1; b <= 11; b++) q.push_back((v >> b) & 1);
        while (q.size() < nfalls) q.push_back(0);
        frame    = cfg[0] ? 13 : 24;
        complete = (nfalls >= frame);

        header(lead, cfg, chg);
        chk({tag, "_oe_pre"}, 32'(adc_miso_oe), 32'd0);
        for (int i = 0; i < nfalls; i++) begin
            adc_clk = 1'b0;
            tick(H);
            chk($sformatf("%s_miso%0d", tag, i), 32'(adc_miso), 32'(q[i]));
            if (i == 0 || i == nfalls - 1) chk($sformatf("%s_oe%0d", tag, i), 32'(adc_miso_oe), 32'd1);
            adc_clk = 1'b1;
            tick(H);
        end
        done_cnt  = 0;
        abort_cnt = 0;
        adc_cs = 1'b1;
        tick(4);
        chk({tag, "_oe_off"}, 32'(adc_miso_oe), 32'd0);
        chk({tag, "_miso_off"}, 32'(adc_miso), 32'd0);
        tick(H);
        adc_clk = 1'b0;
        tick(H);
        chk({tag, "_done"}, 32'(done_cnt), 32'(complete));
        chk({tag, "_abort"}, 32'(abort_cnt), 32'(!complete));
        if (complete) last_cfg = cfg;
        chk({tag, "_cfg"}, 32'(xfer_cfg), 32'(last_cfg));
    endtask

    initial begin
        logic [2:0] rcfg;
        int nf;
        reset      = 1'b1;
        adc_clk    = 1'b0;
        adc_cs     = 1'b1;
        adc_mosi   = 1'b0;
        sample_ch0 = 12'd0;
        sample_ch1 = 12'd0;
        tick(3);
        chk("rst_miso",  32'(adc_miso),    32'd0);
        chk("rst_oe",    32'(adc_miso_oe), 32'd0);
        chk("rst_done",  32'(xfer_done),   32'd0);
        chk("rst_abort", 32'(xfer_abort),  32'd0);
        chk("rst_cfg",   32'(xfer_cfg),    32'd0);
        reset = 1'b0;
        tick(20);

        // Single-ended channel 0, MSB first
        sample_ch0 = 12'hA5C;
        sample_ch1 = 12'h123;
        run_xfer("sgl_ch0", 0, 3'b101, 14, 1'b0);

        // Single-ended channel 1, LSB-first tail
        sample_ch1 = 12'h801;
        run_xfer("sgl_ch1_lsb", 0, 3'b110, 25, 1'b0);

        // Differential with clamping
        sample_ch0 = 12'h300;
        sample_ch1 = 12'h100;
        run_xfer("diff_pos", 0, 3'b001, 14, 1'b0);
        run_xfer("diff_neg", 0, 3'b011, 14, 1'b0);
        sample_ch0 = 12'hFFF;
        sample_ch1 = 12'h000;
        run_xfer("diff_full", 0, 3'b001, 14, 1'b0);

        // Leading zeros, and a sample change right after capture
        sample_ch0 = 12'($urandom);
        run_xfer("lead_chg", 3, 3'b101, 14, 1'b1);

        // Abort after B7, then a normal transfer
        sample_ch0 = 12'($urandom);
        sample_ch1 = 12'($urandom);
        run_xfer("abort", 0, 3'b111, 6, 1'b0);
        run_xfer("post_abort", 1, 3'b100, 14, 1'b0);

        // Reset in the middle of the MSB phase with cs held low
        header(0, 3'b101, 1'b0);
        for (int i = 0; i < 4; i++) begin
            adc_clk = 1'b0;
            tick(H);
            adc_clk = 1'b1;
            tick(H);
        end
        reset = 1'b1;
        tick(1);
        chk("mid_rst_miso",  32'(adc_miso),    32'd0);
        chk("mid_rst_oe",    32'(adc_miso_oe), 32'd0);
        chk("mid_rst_done",  32'(xfer_done),   32'd0);
        chk("mid_rst_abort", 32'(xfer_abort),  32'd0);
        chk("mid_rst_cfg",   32'(xfer_cfg),    32'd0);
        last_cfg = 3'b000;
        reset    = 1'b0;
        oe_seen  = 1'b0;
        adc_mosi = 1'b1;
        for (int i = 0; i < 20; i++) begin
            adc_clk = 1'b0;
            tick(H);
            adc_clk = 1'b1;
            tick(H);
        end
        adc_clk  = 1'b0;
        adc_mosi = 1'b0;
        tick(H);
        chk("held_cs_no_oe", 32'(oe_seen), 32'd0);
        adc_cs = 1'b1;
        tick(20);
        run_xfer("post_reset", 0, 3'b101, 14, 1'b0);

        // Randomized transfers
        for (int t = 0; t < 8; t++) begin
            sample_ch0 = 12'($urandom);
            sample_ch1 = 12'($urandom);
            rcfg = 3'($urandom_range(0, 7));
            nf   = (rcfg[0] ? 13 : 24) + int'($urandom_range(0, 3));
            run_xfer($sformatf("rnd%0d", t), int'($urandom_range(0, 2)), rcfg, nf, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
